// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: op encodings and the per-stage
// payload, sized for the widest supported word so one type serves every WIDTH.
package shifter_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_S     = 6;
  localparam int MAX_TAG_W = 16;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'b00,
    SHOP_SRL = 2'b01,
    SHOP_SRA = 2'b10,
    SHOP_ROR = 2'b11
  } shop_e;

  // Bits above WIDTH / TAG_W are carried as zero.
  typedef struct packed {
    logic [MAX_W-1:0]     data;
    logic [MAX_S-1:0]     k;
    shop_e                op;
    logic                 sign;
    logic                 big;
    logic [MAX_TAG_W-1:0] tag;
    logic                 valid;
  } stage_pl_t;

endpackage

// File: rtl/shifter_pipe_if.sv
// Operation/result handshake bundle of the shifter; slave is the shifter,
// master is the operand issuer that also consumes results.
interface shifter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [31:0]      in_amount;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amount, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amount, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_tag
  );
endinterface

// File: rtl/shifter_stage.sv
// One pipeline stage: conditional right shift/rotate by 2^IDX, then a register
// that loads 'load' when en is high. Latency 1; holds everything while en=0.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX   = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  stage_pl_t d,
  input  stage_pl_t load,
  output stage_pl_t shifted,
  output stage_pl_t q
);

  localparam int SH = 1 << IDX;

  logic [WIDTH-1:0] x;
  logic             fill;

  // SLL arrives bit-reversed, so only right shifts and rotates exist here.
  always_comb begin
    shifted = d;
    x       = d.data[WIDTH-1:0];
    fill    = (d.op == SHOP_SRA) ? d.sign : 1'b0;
    if (d.k[IDX]) begin
      if (d.op == SHOP_ROR) begin
        shifted.data[WIDTH-1:0] = {x[SH-1:0], x[WIDTH-1:SH]};
      end else begin
        shifted.data[WIDTH-1:0] = {{SH{fill}}, x[WIDTH-1:SH]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= load;
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), log2(WIDTH) cycles, one op per cycle.
// Whole pipe stalls while a result waits on out_ready; in_ready follows the stall.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  shifter_pipe_if.slave bus
);

  localparam int S = $clog2(WIDTH);

  stage_pl_t [S:0]   chain;
  stage_pl_t [S-1:0] shifted;
  stage_pl_t [S-1:0] load;
  stage_pl_t         front;
  stage_pl_t         fin;
  logic [WIDTH-1:0]  fin_data;
  logic              zero_q;
  logic              en;
  logic              unused_payload;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) begin
      bitrev[i] = x[WIDTH-1-i];
    end
  endfunction

  assign en = !(chain[S].valid && !bus.out_ready);

  // Amount is classified once here; later stages only see k and big.
  always_comb begin
    front       = '0;
    front.op    = shop_e'(bus.in_op);
    front.data[WIDTH-1:0] = (front.op == SHOP_SLL) ? bitrev(bus.in_data) : bus.in_data;
    front.k[S-1:0] = bus.in_amount[S-1:0];
    front.big   = |bus.in_amount[31:S];
    front.sign  = bus.in_data[WIDTH-1];
    front.tag[TAG_W-1:0] = bus.in_tag;
    front.valid = bus.in_valid;
  end

  assign chain[0] = front;

  for (genvar i = 0; i < S; i++) begin : g_st
    shifter_stage #(
      .WIDTH (WIDTH),
      .IDX   (i)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .d       (chain[i]),
      .load    (load[i]),
      .shifted (shifted[i]),
      .q       (chain[i+1])
    );

    if (i == S - 1) begin : g_last
      assign load[i] = fin;
    end else begin : g_mid
      assign load[i] = shifted[i];
    end
  end

  // Final stage: undo the SLL reversal, then force oversize shifts.
  always_comb begin
    fin      = shifted[S-1];
    fin_data = shifted[S-1].data[WIDTH-1:0];
    if (fin.op == SHOP_SLL) begin
      fin_data = bitrev(fin_data);
    end
    if (fin.big) begin
      case (fin.op)
        SHOP_SLL, SHOP_SRL: fin_data = '0;
        SHOP_SRA:           fin_data = {WIDTH{fin.sign}};
        default:            ;
      endcase
    end
    fin.data[WIDTH-1:0] = fin_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else if (en) begin
      zero_q <= (fin_data == '0);
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = chain[S].valid;
  assign bus.out_data  = chain[S].data[WIDTH-1:0];
  assign bus.out_tag   = chain[S].tag[TAG_W-1:0];
  assign bus.out_zero  = zero_q;

  assign unused_payload = ^chain[S];

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe at WIDTH 32, 8 and 64 against an arithmetic reference model.
module tb_shifter_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shifter_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
  shifter_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();
  shifter_pipe_if #(.WIDTH(64), .TAG_W(4)) b64 ();

  shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  shifter_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .rst(rst), .bus(b8));
  shifter_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  // Reference: shift semantics stated directly on the full 32-bit amount.
  function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input logic [31:0] amt,
                                            input logic [1:0] op, input int w);
    logic [63:0] mask, a;
    logic        sign;
    int unsigned r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    sign = a[w-1];
    case (op)
      2'd0: ref_shift = (amt >= 32'(w)) ? 64'd0 : ((a << amt) & mask);
      2'd1: ref_shift = (amt >= 32'(w)) ? 64'd0 : (a >> amt);
      2'd2: begin
        if (amt >= 32'(w)) ref_shift = sign ? mask : 64'd0;
        else ref_shift = (a >> amt) | (sign ? (mask & ~(mask >> amt)) : 64'd0);
      end
      default: begin
        r = amt % 32'(w);
        ref_shift = (r == 0) ? a : (((a >> r) | (a << (32'(w) - r))) & mask);
      end
    endcase
  endfunction

  task automatic rand_op32(output logic [31:0] d, output logic [31:0] a,
                           output logic [1:0] op, output logic [3:0] t);
    d  = $urandom;
    a  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
    op = 2'($urandom_range(0, 3));
    t  = 4'($urandom_range(0, 15));
  endtask

  task automatic idle_all();
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_amount = '0; b32.in_op = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_amount  = '0; b8.in_op  = '0; b8.in_tag  = '0; b8.out_ready  = 1'b1;
    b64.in_valid = 1'b0; b64.in_data = '0; b64.in_amount = '0; b64.in_op = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b0 || b32.out_data !== '0 || b32.out_tag !== '0 || b32.out_zero !== 1'b1) begin
      failures++;
      $display("FAIL reset32: valid=%b data=%h tag=%h zero=%b, required 0 0 0 1",
               b32.out_valid, b32.out_data, b32.out_tag, b32.out_zero);
    end
    checks++;
    if (b8.out_valid !== 1'b0 || b8.out_data !== '0 || b64.out_valid !== 1'b0 || b64.out_data !== '0 ||
        b8.out_zero !== 1'b1 || b64.out_zero !== 1'b1) begin
      failures++;
      $display("FAIL reset8_64: v8=%b d8=%h z8=%b v64=%b d64=%h z64=%b, required 0 0 1 0 0 1",
               b8.out_valid, b8.out_data, b8.out_zero, b64.out_valid, b64.out_data, b64.out_zero);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (b32.in_ready !== 1'b1 || b8.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b%b%b, required 111", b32.in_ready, b8.in_ready, b64.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] td [8] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h00000001,
                            32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hDEADBEEF};
    logic [31:0] ta [8] = '{32'd4, 32'd31, 32'd4, 32'd1, 32'd40, 32'h100, 32'd33, 32'd32};
    logic [1:0]  to [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] te [8] = '{32'h00000010, 32'h00000001, 32'hF8000000, 32'h80000000,
                            32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 8; i++) begin
      int lat;
      @(negedge clk);
      b32.in_valid = 1'b1; b32.in_data = td[i]; b32.in_amount = ta[i];
      b32.in_op = to[i]; b32.in_tag = 4'(i + 3);
      @(negedge clk);
      b32.in_valid = 1'b0;
      lat = 1;
      while (b32.out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 5 || b32.out_data !== te[i] || b32.out_tag !== 4'(i + 3) || b32.out_zero !== (te[i] == 0)) begin
        failures++;
        $display("FAIL directed[%0d]: lat=%0d data=%h tag=%h zero=%b, required lat=5 data=%h tag=%h zero=%b",
                 i, lat, b32.out_data, b32.out_tag, b32.out_zero, te[i], 4'(i + 3), te[i] == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qd [$];
    logic [3:0]  qt [$];
    logic [31:0] d, a, ed;
    logic [63:0] e;
    logic [1:0]  op;
    logic [3:0]  t, et;
    int issued, got, first, last;
    issued = 0; got = 0; first = -1; last = -1;
    b32.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (issued < 20 || qd.size() > 0); cyc++) begin
      @(negedge clk);
      #1;
      if (b32.out_valid === 1'b1) begin
        checks++;
        if (qd.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: data=%h tag=%h, required no result", b32.out_data, b32.out_tag);
        end else begin
          ed = qd.pop_front(); et = qt.pop_front(); got++;
          if (first < 0) first = cyc;
          last = cyc;
          if (b32.out_data !== ed || b32.out_tag !== et || b32.out_zero !== (ed == 0)) begin
            failures++;
            $display("FAIL b2b_result[%0d]: data=%h tag=%h zero=%b, required %h %h %b",
                     got, b32.out_data, b32.out_tag, b32.out_zero, ed, et, ed == 0);
          end
        end
      end
      if (issued < 20) begin
        rand_op32(d, a, op, t);
        b32.in_valid = 1'b1; b32.in_data = d; b32.in_amount = a; b32.in_op = op; b32.in_tag = t;
        if (b32.in_ready === 1'b1) begin
          e = ref_shift({32'd0, d}, a, op, 32);
          qd.push_back(e[31:0]); qt.push_back(t); issued++;
        end
      end else begin
        b32.in_valid = 1'b0;
      end
    end
    b32.in_valid = 1'b0;
    checks++;
    if (issued != 20 || got != 20 || qd.size() != 0 || (last - first) != 19) begin
      failures++;
      $display("FAIL b2b_rate: issued=%0d got=%0d span=%0d, required 20 20 19", issued, got, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] qd [$];
    logic [3:0]  qt [$];
    logic [31:0] pd, pa, hd, ed;
    logic [63:0] e;
    logic [1:0]  po;
    logic [3:0]  pt, ht, et;
    logic        pend;
    int issued, got;
    pend = 1'b0; issued = 0; got = 0; hd = '0; ht = '0;
    pd = '0; pa = '0; po = '0; pt = '0;
    for (int cyc = 0; cyc < 100 && (issued < 16 || qd.size() > 0); cyc++) begin
      @(negedge clk);
      b32.out_ready = !(cyc >= 8 && cyc < 11);
      #1;
      if (!b32.out_ready) begin
        checks++;
        if (b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_stall cyc=%0d: in_ready=%b out_valid=%b, required 0 1", cyc, b32.in_ready, b32.out_valid);
        end
        if (cyc == 8) begin
          hd = b32.out_data; ht = b32.out_tag;
        end else begin
          checks++;
          if (b32.out_data !== hd || b32.out_tag !== ht) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d: data=%h tag=%h, required %h %h", cyc, b32.out_data, b32.out_tag, hd, ht);
          end
        end
      end else if (b32.out_valid === 1'b1) begin
        checks++;
        if (qd.size() == 0) begin
          failures++;
          $display("FAIL bp_extra: data=%h tag=%h, required no result", b32.out_data, b32.out_tag);
        end else begin
          ed = qd.pop_front(); et = qt.pop_front(); got++;
          if (b32.out_data !== ed || b32.out_tag !== et) begin
            failures++;
            $display("FAIL bp_result[%0d]: data=%h tag=%h, required %h %h", got, b32.out_data, b32.out_tag, ed, et);
          end
        end
      end
      if (issued < 16) begin
        if (!pend) begin
          rand_op32(pd, pa, po, pt);
          pend = 1'b1;
        end
        b32.in_valid = 1'b1; b32.in_data = pd; b32.in_amount = pa; b32.in_op = po; b32.in_tag = pt;
        if (b32.in_ready === 1'b1) begin
          e = ref_shift({32'd0, pd}, pa, po, 32);
          qd.push_back(e[31:0]); qt.push_back(pt); issued++; pend = 1'b0;
        end
      end else begin
        b32.in_valid = 1'b0;
      end
    end
    b32.out_ready = 1'b1;
    b32.in_valid  = 1'b0;
    checks++;
    if (issued != 16 || got != 16 || qd.size() != 0) begin
      failures++;
      $display("FAIL bp_count: issued=%0d got=%0d left=%0d, required 16 16 0", issued, got, qd.size());
    end
  endtask

  task automatic test_reset_midstream();
    int lat, stale;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b32.in_valid  = 1'b1;
      b32.in_data   = (i == 0) ? 32'h00000001 : $urandom;
      b32.in_amount = (i == 0) ? 32'd1 : $urandom_range(0, 31);
      b32.in_op     = (i == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      b32.in_tag    = 4'(5 + i);
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b32.out_valid !== 1'b1 || b32.out_data !== 32'h80000000 || b32.out_tag !== 4'd5) begin
      failures++;
      $display("FAIL rst_pre: valid=%b data=%h tag=%h, required 1 80000000 5", b32.out_valid, b32.out_data, b32.out_tag);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b32.out_data !== '0 || b32.out_tag !== '0 || b32.out_zero !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid: valid=%b data=%h tag=%h zero=%b, required 0 0 0 1",
               b32.out_valid, b32.out_data, b32.out_tag, b32.out_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b32.in_valid = 1'b1; b32.in_data = 32'h80000000; b32.in_amount = 32'd4; b32.in_op = 2'd2; b32.in_tag = 4'd9;
    #1;
    checks++;
    if (b32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_ready: in_ready=%b, required 1", b32.in_ready);
    end
    @(negedge clk);
    b32.in_valid = 1'b0;
    lat = 1;
    while (b32.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 5 || b32.out_data !== 32'hF8000000 || b32.out_tag !== 4'd9) begin
      failures++;
      $display("FAIL rst_new_op: lat=%0d data=%h tag=%h, required 5 f8000000 9", lat, b32.out_data, b32.out_tag);
    end
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (b32.out_valid === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL rst_stale: extra results=%0d, required 0", stale);
    end
  endtask

  task automatic test_sweep8();
    for (int op = 0; op < 4; op++) begin
      for (int amt = 0; amt <= 16; amt++) begin
        logic [7:0]  d;
        logic [63:0] e;
        int lat;
        d = 8'($urandom);
        e = ref_shift({56'd0, d}, 32'(amt), 2'(op), 8);
        @(negedge clk);
        b8.in_valid = 1'b1; b8.in_data = d; b8.in_amount = 32'(amt); b8.in_op = 2'(op); b8.in_tag = 4'(amt);
        @(negedge clk);
        b8.in_valid = 1'b0;
        lat = 1;
        while (b8.out_valid !== 1'b1 && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        checks++;
        if (lat != 3 || b8.out_data !== e[7:0] || b8.out_tag !== 4'(amt) || b8.out_zero !== (e[7:0] == 8'd0)) begin
          failures++;
          $display("FAIL sweep8 op=%0d amt=%0d in=%h: lat=%0d data=%h tag=%h zero=%b, required lat=3 data=%h tag=%h zero=%b",
                   op, amt, d, lat, b8.out_data, b8.out_tag, b8.out_zero, e[7:0], 4'(amt), e[7:0] == 8'd0);
        end
      end
    end
  endtask

  task automatic test_sweep64();
    for (int op = 0; op < 4; op++) begin
      for (int amt = 0; amt <= 128; amt++) begin
        logic [63:0] d, e;
        int lat;
        d = {$urandom, $urandom};
        e = ref_shift(d, 32'(amt), 2'(op), 64);
        @(negedge clk);
        b64.in_valid = 1'b1; b64.in_data = d; b64.in_amount = 32'(amt); b64.in_op = 2'(op); b64.in_tag = 4'(amt);
        @(negedge clk);
        b64.in_valid = 1'b0;
        lat = 1;
        while (b64.out_valid !== 1'b1 && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        checks++;
        if (lat != 6 || b64.out_data !== e || b64.out_tag !== 4'(amt) || b64.out_zero !== (e == 64'd0)) begin
          failures++;
          $display("FAIL sweep64 op=%0d amt=%0d in=%h: lat=%0d data=%h tag=%h zero=%b, required lat=6 data=%h tag=%h zero=%b",
                   op, amt, d, lat, b64.out_data, b64.out_tag, b64.out_zero, e, 4'(amt), e == 64'd0);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_sweep8();
    test_sweep64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
